// File: rtl/port_mem_arbiter.sv
// Shares one single-port synchronous RAM between the peripheral memory ports:
// fixed priority for the video channels, round-robin for the rest, fixed 2-cycle latency.
module port_mem_arbiter #(
    parameter int             NCH        = 6,
    parameter int             AW         = 16,
    parameter int             DW         = 16,
    parameter logic [NCH-1:0] HIPRI_MASK = 6'b001111,
    parameter logic [NCH-1:0] WRITE_MASK = 6'b010000
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH*DW-1:0] req_wdata,
    output logic [NCH-1:0]    req_ready,
    output logic [DW-1:0]     req_rdata,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DW-1:0]     mem_rdata,
    output logic [2:0]        grant_ch
);

    function automatic logic [2:0] first_low_ch();
        logic [2:0] r;
        r = 3'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!HIPRI_MASK[i]) r = 3'(i);
        end
        return r;
    endfunction

    localparam logic [2:0] RR_INIT = first_low_ch();

    logic [AW-1:0]  addr_arr  [NCH];
    logic [DW-1:0]  wdata_arr [NCH];
    logic [NCH-1:0] eligible;

    logic [NCH-1:0] pending_reg, pending_next;
    logic [NCH-1:0] req_ready_reg, req_ready_next;
    logic [DW-1:0]  req_rdata_reg;
    logic [AW-1:0]  mem_addr_reg;
    logic [DW-1:0]  mem_wdata_reg;
    logic           mem_rd_reg, mem_wr_reg;
    logic [2:0]     grant_ch_reg;
    logic           s2_valid_reg, s2_rd_reg;
    logic [2:0]     s2_ch_reg;
    logic [2:0]     rr_ptr_reg, rr_ptr_next;

    logic           grant_valid, grant_lo;
    logic [2:0]     win_ch;

    // A channel whose ready is high this cycle is still busy; it may re-request next cycle.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
            assign eligible[gi]  = req_valid[gi] & ~pending_reg[gi] & ~req_ready_reg[gi];
        end
    endgenerate

    always_comb begin
        logic [2:0] idx;
        logic       found;
        grant_valid = 1'b0;
        grant_lo    = 1'b0;
        win_ch      = 3'd0;
        rr_ptr_next = rr_ptr_reg;
        idx         = 3'd0;
        found       = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_valid && HIPRI_MASK[i] && eligible[i]) begin
                grant_valid = 1'b1;
                win_ch      = 3'(i);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            idx = 3'((int'(rr_ptr_reg) + k) % NCH);
            if (!grant_valid && !HIPRI_MASK[idx] && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_lo    = 1'b1;
                win_ch      = idx;
            end
        end
        if (grant_lo) begin
            for (int k = 1; k <= NCH; k++) begin
                idx = 3'((int'(win_ch) + k) % NCH);
                if (!found && !HIPRI_MASK[idx]) begin
                    found       = 1'b1;
                    rr_ptr_next = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready_next = '0;
        if (s2_valid_reg) req_ready_next[s2_ch_reg] = 1'b1;
        pending_next = pending_reg & ~req_ready_next;
        if (grant_valid) pending_next[win_ch] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            pending_reg   <= '0;
            req_ready_reg <= '0;
            req_rdata_reg <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            grant_ch_reg  <= 3'd0;
            s2_valid_reg  <= 1'b0;
            s2_rd_reg     <= 1'b0;
            s2_ch_reg     <= 3'd0;
            rr_ptr_reg    <= RR_INIT;
        end else begin
            mem_rd_reg <= grant_valid & ~WRITE_MASK[win_ch];
            mem_wr_reg <= grant_valid & WRITE_MASK[win_ch];
            if (grant_valid) begin
                mem_addr_reg  <= addr_arr[win_ch];
                mem_wdata_reg <= wdata_arr[win_ch];
                grant_ch_reg  <= win_ch;
            end
            // The issue registers double as stage 1; stage 2 lines up with RAM read data.
            s2_valid_reg  <= mem_rd_reg | mem_wr_reg;
            s2_rd_reg     <= mem_rd_reg;
            s2_ch_reg     <= grant_ch_reg;
            if (s2_valid_reg && s2_rd_reg) req_rdata_reg <= mem_rdata;
            req_ready_reg <= req_ready_next;
            pending_reg   <= pending_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign req_rdata = req_rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign grant_ch  = grant_ch_reg;

endmodule

// File: tb/tb_port_mem_arbiter.sv
// Directed bench for port_mem_arbiter with a small behavioural RAM model
// (one-cycle registered read, write on the strobe edge).
module tb_port_mem_arbiter;

    localparam int NCH = 6;
    localparam int AW  = 16;
    localparam int DW  = 16;

    logic              CLK;
    logic              RSTb;
    logic [NCH-1:0]    req_valid;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_ready;
    logic [DW-1:0]     req_rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wr;
    logic              mem_rd;
    logic [DW-1:0]     mem_rdata;
    logic [2:0]        grant_ch;

    logic [DW-1:0] ram [0:1023];
    logic          bd_we;
    logic [9:0]    bd_addr;
    logic [DW-1:0] bd_data;

    int checks = 0;
    int passed = 0;

    port_mem_arbiter dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .grant_ch  (grant_ch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        if (mem_wr) ram[mem_addr[9:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[ch*AW +: AW]  = a;
        req_wdata[ch*DW +: DW] = d;
    endtask

    task automatic test_reset();
        RSTb = 1'b0;
        req_valid = '0;
        tick();
        tick();
        checks++;
        if ({req_ready, mem_rd, mem_wr, grant_ch} !== 11'd0)
            $display("FAIL reset_ctrl: got %h expected 0", {req_ready, mem_rd, mem_wr, grant_ch});
        else passed++;
        checks++;
        if ({req_rdata, mem_addr, mem_wdata} !== 48'd0)
            $display("FAIL reset_data: got %h expected 0", {req_rdata, mem_addr, mem_wdata});
        else passed++;
        RSTb = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_single_read();
        bd_we = 1'b1; bd_addr = 10'h123; bd_data = 16'hBEEF;
        tick();
        bd_we = 1'b0;
        set_ch(1, 16'h0123, 16'h0000);
        req_valid[1] = 1'b1;
        tick();
        checks++;
        if ({mem_rd, mem_wr, grant_ch, mem_addr} !== {1'b1, 1'b0, 3'd1, 16'h0123})
            $display("FAIL read_issue: got rd=%b wr=%b ch=%0d addr=%h expected rd=1 wr=0 ch=1 addr=0123",
                     mem_rd, mem_wr, grant_ch, mem_addr);
        else passed++;
        tick();
        checks++;
        if ({req_ready, mem_rd} !== 7'd0)
            $display("FAIL read_wait: got ready=%b rd=%b expected ready=000000 rd=0", req_ready, mem_rd);
        else passed++;
        tick();
        checks++;
        if (req_ready !== 6'b000010 || req_rdata !== 16'hBEEF)
            $display("FAIL read_done: got ready=%b rdata=%h expected ready=000010 rdata=beef", req_ready, req_rdata);
        else passed++;
        req_valid[1] = 1'b0;
        tick();
        checks++;
        if (req_ready !== 6'b000000)
            $display("FAIL read_pulse: got ready=%b expected 000000", req_ready);
        else passed++;
        $display("read ch1 addr 0123 -> %h", req_rdata);
    endtask

    task automatic test_single_write();
        set_ch(4, 16'h0200, 16'h5A5A);
        req_valid[4] = 1'b1;
        tick();
        checks++;
        if ({mem_wr, mem_rd, grant_ch, mem_addr, mem_wdata} !== {1'b1, 1'b0, 3'd4, 16'h0200, 16'h5A5A})
            $display("FAIL write_issue: got wr=%b rd=%b ch=%0d addr=%h wdata=%h expected wr=1 rd=0 ch=4 addr=0200 wdata=5a5a",
                     mem_wr, mem_rd, grant_ch, mem_addr, mem_wdata);
        else passed++;
        tick();
        tick();
        checks++;
        if (req_ready !== 6'b010000 || req_rdata !== 16'hBEEF)
            $display("FAIL write_done: got ready=%b rdata=%h expected ready=010000 rdata=beef", req_ready, req_rdata);
        else passed++;
        req_valid[4] = 1'b0;
        tick();
        set_ch(0, 16'h0200, 16'h0000);
        req_valid[0] = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (req_ready !== 6'b000001 || req_rdata !== 16'h5A5A)
            $display("FAIL write_readback: got ready=%b rdata=%h expected ready=000001 rdata=5a5a", req_ready, req_rdata);
        else passed++;
        req_valid[0] = 1'b0;
        tick();
        $display("write ch4 addr 0200 data 5a5a, readback ch0 -> %h", req_rdata);
    endtask

    task automatic test_priority();
        logic [2:0]  exp_ch   [3];
        logic [15:0] exp_addr [3];
        exp_ch[0] = 3'd0; exp_ch[1] = 3'd2; exp_ch[2] = 3'd5;
        exp_addr[0] = 16'h0010; exp_addr[1] = 16'h0020; exp_addr[2] = 16'h0030;
        set_ch(0, 16'h0010, 16'h0000);
        set_ch(2, 16'h0020, 16'h0000);
        set_ch(5, 16'h0030, 16'h0000);
        req_valid = 6'b100101;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (mem_rd !== 1'b1 || grant_ch !== exp_ch[k] || mem_addr !== exp_addr[k])
                $display("FAIL prio_grant%0d: got rd=%b ch=%0d addr=%h expected rd=1 ch=%0d addr=%h",
                         k, mem_rd, grant_ch, mem_addr, exp_ch[k], exp_addr[k]);
            else passed++;
            $display("prio grant %0d -> ch%0d", k, grant_ch);
        end
        checks++;
        if (req_ready !== 6'b000001)
            $display("FAIL prio_ready0: got %b expected 000001", req_ready);
        else passed++;
        req_valid[0] = 1'b0;
        tick();
        checks++;
        if (req_ready !== 6'b000100 || mem_rd !== 1'b0)
            $display("FAIL prio_ready2: got ready=%b rd=%b expected ready=000100 rd=0", req_ready, mem_rd);
        else passed++;
        req_valid[2] = 1'b0;
        tick();
        checks++;
        if (req_ready !== 6'b100000)
            $display("FAIL prio_ready5: got %b expected 100000", req_ready);
        else passed++;
        req_valid[5] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_act;
        logic [2:0] exp_ch [8];
        logic [5:0] exp_rdy [8];
        exp_act = 8'b00110011;
        exp_ch[0] = 3'd4; exp_ch[1] = 3'd5; exp_ch[4] = 3'd4; exp_ch[5] = 3'd5;
        exp_ch[2] = 3'd0; exp_ch[3] = 3'd0; exp_ch[6] = 3'd0; exp_ch[7] = 3'd0;
        for (int k = 0; k < 8; k++) exp_rdy[k] = 6'b000000;
        exp_rdy[2] = 6'b010000; exp_rdy[3] = 6'b100000;
        exp_rdy[6] = 6'b010000; exp_rdy[7] = 6'b100000;
        set_ch(4, 16'h0300, 16'h1234);
        set_ch(5, 16'h0040, 16'h0000);
        req_valid = 6'b110000;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ((mem_rd | mem_wr) !== exp_act[k] || (exp_act[k] && grant_ch !== exp_ch[k]) || req_ready !== exp_rdy[k])
                $display("FAIL rr_cycle%0d: got act=%b ch=%0d ready=%b expected act=%b ch=%0d ready=%b",
                         k, mem_rd | mem_wr, grant_ch, req_ready, exp_act[k], exp_ch[k], exp_rdy[k]);
            else passed++;
            if (exp_act[k]) $display("rr cycle %0d grant ch%0d", k, grant_ch);
        end
        req_valid = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        set_ch(3, 16'h0123, 16'h0000);
        req_valid[3] = 1'b1;
        tick();
        checks++;
        if (mem_rd !== 1'b1 || grant_ch !== 3'd3)
            $display("FAIL b2b_first: got rd=%b ch=%0d expected rd=1 ch=3", mem_rd, grant_ch);
        else passed++;
        tick();
        tick();
        checks++;
        if (req_ready !== 6'b001000 || req_rdata !== 16'hBEEF)
            $display("FAIL b2b_ready: got ready=%b rdata=%h expected ready=001000 rdata=beef", req_ready, req_rdata);
        else passed++;
        tick();
        checks++;
        if (mem_rd !== 1'b0 || req_ready !== 6'b000000)
            $display("FAIL b2b_no_regrant: got rd=%b ready=%b expected rd=0 ready=000000", mem_rd, req_ready);
        else passed++;
        tick();
        checks++;
        if (mem_rd !== 1'b1 || grant_ch !== 3'd3)
            $display("FAIL b2b_regrant: got rd=%b ch=%0d expected rd=1 ch=3", mem_rd, grant_ch);
        else passed++;
        tick();
        tick();
        checks++;
        if (req_ready !== 6'b001000)
            $display("FAIL b2b_second_ready: got %b expected 001000", req_ready);
        else passed++;
        req_valid[3] = 1'b0;
        tick();
        $display("back-to-back ch3 two reads complete");
    endtask

    task automatic test_reset_mid_op();
        set_ch(1, 16'h0123, 16'h0000);
        req_valid[1] = 1'b1;
        tick();
        checks++;
        if (mem_rd !== 1'b1 || grant_ch !== 3'd1)
            $display("FAIL rst_grant: got rd=%b ch=%0d expected rd=1 ch=1", mem_rd, grant_ch);
        else passed++;
        RSTb = 1'b0;
        tick();
        checks++;
        if ({req_ready, mem_rd, mem_wr, grant_ch, req_rdata, mem_addr, mem_wdata} !== 59'd0)
            $display("FAIL rst_outputs: got %h expected 0",
                     {req_ready, mem_rd, mem_wr, grant_ch, req_rdata, mem_addr, mem_wdata});
        else passed++;
        req_valid[1] = 1'b0;
        RSTb = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (req_ready !== 6'b000000)
            $display("FAIL rst_no_ready: got %b expected 000000", req_ready);
        else passed++;
        req_valid[1] = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (req_ready !== 6'b000010 || req_rdata !== 16'hBEEF)
            $display("FAIL rst_recover: got ready=%b rdata=%h expected ready=000010 rdata=beef", req_ready, req_rdata);
        else passed++;
        req_valid[1] = 1'b0;
        tick();
        $display("reset mid-op, ch1 recovered -> %h", req_rdata);
    endtask

    initial begin
        RSTb      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_priority();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
